// File: rtl/bus_slave_mem_if.sv
// Request/acknowledge bus between a master and the bus_slave_mem storage target.
// Optional macro BUS_SLAVE_MEM_WSTRB_EN adds the m_wstrb byte-lane strobes.
interface bus_slave_mem_if;
    logic        m_req;
    logic        m_wr;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
`ifdef BUS_SLAVE_MEM_WSTRB_EN
    logic [3:0]  m_wstrb;
`endif
    logic        s_ack;
    logic        s_err;
    logic [31:0] s_rdata;
    logic        s_busy;

    modport master (
`ifdef BUS_SLAVE_MEM_WSTRB_EN
        output m_wstrb,
`endif
        output m_req, m_wr, m_addr, m_wdata,
        input  s_ack, s_err, s_rdata, s_busy
    );

    modport slave (
`ifdef BUS_SLAVE_MEM_WSTRB_EN
        input  m_wstrb,
`endif
        input  m_req, m_wr, m_addr, m_wdata,
        output s_ack, s_err, s_rdata, s_busy
    );
endinterface

// File: rtl/bus_slave_mem.sv
// Bus slave memory: captures one request, waits WAIT_CYC cycles, accesses a
// local register array, then acknowledges for one cycle with data and error.
// Optional macro BUS_SLAVE_MEM_WSTRB_EN enables per-byte write strobes.
module bus_slave_mem #(
    parameter logic [7:0] BASE_ADDR  = 8'h20,
    parameter int         DEPTH_LOG2 = 5,
    parameter int         WAIT_CYC   = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_slave_mem_if.slave bus
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [9:0] DEPTH_LIM = 10'(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];
`ifdef BUS_SLAVE_MEM_WSTRB_EN
    logic [3:0]  wstrb_q, wstrb_d;
`endif

    logic [8:0]            offset;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           wr_word;

    // Decode the latched address; 9-bit subtraction so addresses below the base never alias
    always_comb begin
        offset   = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        in_range = ({1'b0, offset} < DEPTH_LIM);
        idx      = offset[DEPTH_LOG2-1:0];
    end

    // Build the word to store, merging enabled byte lanes over the current contents
    always_comb begin
`ifdef BUS_SLAVE_MEM_WSTRB_EN
        wr_word = mem_q[idx];
        for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
                wr_word[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
`else
        wr_word = wdata_q;
`endif
    end

    // Transaction FSM: capture in IDLE, count wait states, access memory, respond
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_d   = mem_q;
`ifdef BUS_SLAVE_MEM_WSTRB_EN
        wstrb_d = wstrb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.m_req) begin
                    wr_d    = bus.m_wr;
                    addr_d  = bus.m_addr;
                    wdata_d = bus.m_wdata;
`ifdef BUS_SLAVE_MEM_WSTRB_EN
                    wstrb_d = bus.m_wstrb;
`endif
                    if (WAIT_CYC > 0) begin
                        cnt_d   = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                err_d = ~in_range;
                if (!in_range) begin
                    rdata_d = 32'h0;
                end else if (wr_q) begin
                    mem_d[idx] = wr_word;
                end else begin
                    rdata_d = mem_q[idx];
                end
                state_d = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, request latch, response data and memory registers with async clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 8'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            mem_q   <= '{default: 32'h0};
`ifdef BUS_SLAVE_MEM_WSTRB_EN
            wstrb_q <= 4'h0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
`ifdef BUS_SLAVE_MEM_WSTRB_EN
            wstrb_q <= wstrb_d;
`endif
        end
    end

    // Outputs decoded from the state register only
    always_comb begin
        bus.s_ack   = (state_q == ST_RESP);
        bus.s_err   = (state_q == ST_RESP) & err_q;
        bus.s_busy  = (state_q != ST_IDLE);
        bus.s_rdata = rdata_q;
    end

endmodule

// File: tb/tb_bus_slave_mem.sv
// Testbench for bus_slave_mem (BASE_ADDR=0x20, 32 words, WAIT_CYC=2).
// Strobe sequence only exercised when BUS_SLAVE_MEM_WSTRB_EN is defined.
module tb_bus_slave_mem;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    bus_slave_mem_if bus();

    bus_slave_mem #(
        .BASE_ADDR (8'h20),
        .DEPTH_LOG2(5),
        .WAIT_CYC  (2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checksPassed = 0;
    int checksTotal  = 0;

`ifdef BUS_SLAVE_MEM_WSTRB_EN
    logic [3:0] tbWstrb = 4'hF;
`endif

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vectors[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One full transaction: request, expect ack in the 4th cycle after capture, drop req on ack
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr, input string tag);
        int          ackAt;
        logic [31:0] gotRdata;
        logic        gotErr;
        ackAt    = 0;
        gotRdata = 'x;
        gotErr   = 1'bx;
        @(negedge clk);
        bus.m_req   = 1'b1;
        bus.m_wr    = wr;
        bus.m_addr  = addr;
        bus.m_wdata = wdata;
`ifdef BUS_SLAVE_MEM_WSTRB_EN
        bus.m_wstrb = tbWstrb;
`endif
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) checkOutput({tag, " busy"}, 32'(bus.s_busy), 32'd1);
            if (bus.s_ack) begin
                ackAt    = k;
                gotRdata = bus.s_rdata;
                gotErr   = bus.s_err;
                break;
            end
        end
        bus.m_req = 1'b0;
        checkOutput({tag, " latency"}, 32'(ackAt), 32'd4);
        checkOutput({tag, " err"}, 32'(gotErr), 32'(expErr));
        checkOutput({tag, " rdata"}, gotRdata, expRdata);
        @(negedge clk);
        checkOutput({tag, " ack width"}, 32'(bus.s_ack), 32'd0);
        checkOutput({tag, " idle busy"}, 32'(bus.s_busy), 32'd0);
    endtask

    initial begin
        int ackCount;
        int ackAt;

        vectors.push_back('{1'b0, 8'h25, 32'h0,        32'h0,        1'b0});
        vectors.push_back('{1'b1, 8'h21, 32'hDEADBEEF, 32'h0,        1'b0});
        vectors.push_back('{1'b0, 8'h21, 32'h0,        32'hDEADBEEF, 1'b0});
        vectors.push_back('{1'b0, 8'h22, 32'h0,        32'h0,        1'b0});
        vectors.push_back('{1'b0, 8'h20, 32'h0,        32'h0,        1'b0});
        vectors.push_back('{1'b0, 8'h3F, 32'h0,        32'h0,        1'b0});
        vectors.push_back('{1'b1, 8'h40, 32'h11111111, 32'h0,        1'b1});
        vectors.push_back('{1'b0, 8'h20, 32'h0,        32'h0,        1'b0});
        vectors.push_back('{1'b0, 8'h21, 32'h0,        32'hDEADBEEF, 1'b0});
        vectors.push_back('{1'b0, 8'h1F, 32'h0,        32'h0,        1'b1});
        vectors.push_back('{1'b1, 8'h3F, 32'hCAFEF00D, 32'h0,        1'b0});
        vectors.push_back('{1'b0, 8'h3F, 32'h0,        32'hCAFEF00D, 1'b0});
        vectors.push_back('{1'b1, 8'hFF, 32'h55555555, 32'h0,        1'b1});
        vectors.push_back('{1'b0, 8'h00, 32'h0,        32'h0,        1'b1});
        vectors.push_back('{1'b0, 8'h21, 32'h0,        32'hDEADBEEF, 1'b0});

        reset_n     = 1'b0;
        bus.m_req   = 1'b0;
        bus.m_wr    = 1'b0;
        bus.m_addr  = 8'h0;
        bus.m_wdata = 32'h0;
`ifdef BUS_SLAVE_MEM_WSTRB_EN
        bus.m_wstrb = 4'hF;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset ack", 32'(bus.s_ack), 32'd0);
        checkOutput("reset err", 32'(bus.s_err), 32'd0);
        checkOutput("reset busy", 32'(bus.s_busy), 32'd0);
        checkOutput("reset rdata", bus.s_rdata, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i].wr, vectors[i].addr, vectors[i].wdata,
                          vectors[i].expRdata, vectors[i].expErr, $sformatf("vec%0d", i));
        end

        // Inputs changed during WAIT are ignored; a second req pulse gives no extra ack
        @(negedge clk);
        bus.m_req   = 1'b1;
        bus.m_wr    = 1'b1;
        bus.m_addr  = 8'h23;
        bus.m_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        ackCount = 0;
        ackAt    = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.s_ack) begin
                ackCount++;
                if (ackAt == 0) ackAt = k;
            end
            if (k == 1) begin
                bus.m_addr  = 8'h24;
                bus.m_wdata = 32'h0;
                bus.m_req   = 1'b0;
            end else if (k == 2) begin
                bus.m_req = 1'b1;
            end else if (k == 3) begin
                bus.m_req = 1'b0;
            end
        end
        checkOutput("wait-ignore ack count", 32'(ackCount), 32'd1);
        checkOutput("wait-ignore latency", 32'(ackAt), 32'd4);
        applyStimulus(1'b0, 8'h23, 32'h0, 32'hA5A5A5A5, 1'b0, "rd23");
        applyStimulus(1'b0, 8'h24, 32'h0, 32'h0, 1'b0, "rd24");

`ifdef BUS_SLAVE_MEM_WSTRB_EN
        tbWstrb = 4'hF;
        applyStimulus(1'b1, 8'h21, 32'hDEADBEEF, 32'h0, 1'b0, "strb full");
        tbWstrb = 4'b0011;
        applyStimulus(1'b1, 8'h21, 32'h12345678, 32'h0, 1'b0, "strb low");
        tbWstrb = 4'b0000;
        applyStimulus(1'b1, 8'h21, 32'hFFFFFFFF, 32'h0, 1'b0, "strb none");
        tbWstrb = 4'hF;
        applyStimulus(1'b0, 8'h21, 32'h0, 32'hDEAD5678, 1'b0, "strb read");
`endif

        // Reset during WAIT aborts a write: no ack, outputs and memory cleared
        applyStimulus(1'b0, 8'h3F, 32'h0, 32'hCAFEF00D, 1'b0, "pre-reset rd");
        @(negedge clk);
        bus.m_req   = 1'b1;
        bus.m_wr    = 1'b1;
        bus.m_addr  = 8'h22;
        bus.m_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset ack", 32'(bus.s_ack), 32'd0);
        checkOutput("midreset err", 32'(bus.s_err), 32'd0);
        checkOutput("midreset busy", 32'(bus.s_busy), 32'd0);
        checkOutput("midreset rdata", bus.s_rdata, 32'h0);
        @(negedge clk);
        reset_n   = 1'b1;
        bus.m_req = 1'b0;
        ackCount  = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.s_ack) ackCount++;
        end
        checkOutput("midreset no ack", 32'(ackCount), 32'd0);
        applyStimulus(1'b0, 8'h22, 32'h0, 32'h0, 1'b0, "post-reset rd22");
        applyStimulus(1'b0, 8'h3F, 32'h0, 32'h0, 1'b0, "post-reset rd3F");

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
